// File: rtl/esc_adc_pkg.sv
// Constants and state encoding shared by the ADC emulator, frame receiver and timing hub.
package esc_adc_pkg;

  localparam int unsigned SAMPLE_W       = 24;
  localparam int unsigned READ_DCLKS_DEF = 24;
  localparam int unsigned TS_DCLKS_DEF   = 128;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } adc_state_t;

endpackage

// File: rtl/adc_shift_tx.sv
// Loadable MSB-first serialiser: after a load, emits NBITS bits on successive dclk edges.
module adc_shift_tx
  import esc_adc_pkg::*;
#(
  parameter int unsigned NBITS = READ_DCLKS_DEF
) (
  input  logic                dclk,
  input  logic                rst_dclk,
  input  logic                clear,
  input  logic                load,
  input  logic [SAMPLE_W-1:0] word,
  output logic                dout,
  output logic                active
);

  localparam int unsigned CNT_W = $clog2(NBITS + 1);

  logic [SAMPLE_W-1:0] sreg;
  logic [CNT_W-1:0]    bits_left;

  always_ff @(posedge dclk or posedge rst_dclk) begin
    if (rst_dclk) begin
      sreg      <= '0;
      bits_left <= '0;
      dout      <= 1'b0;
      active    <= 1'b0;
    end else if (clear) begin
      sreg      <= '0;
      bits_left <= '0;
      dout      <= 1'b0;
      active    <= 1'b0;
    end else if (load) begin
      // Left-justify so bit NBITS-1 of the word is always the first one out.
      sreg      <= word << (SAMPLE_W - NBITS);
      bits_left <= CNT_W'(NBITS);
      dout      <= 1'b0;
      active    <= 1'b0;
    end else if (bits_left != '0) begin
      dout      <= sreg[SAMPLE_W-1];
      sreg      <= {sreg[SAMPLE_W-2:0], 1'b0};
      bits_left <= bits_left - CNT_W'(1);
      active    <= 1'b1;
    end else begin
      dout      <= 1'b0;
      active    <= 1'b0;
    end
  end

endmodule

// File: rtl/adc_frame_emitter.sv
// ADC serial-interface emulator: one DRDY strobe plus MSB-first data frame per sampling period,
// with sync/settle behaviour and single-frame skip injection.
module adc_frame_emitter
  import esc_adc_pkg::*;
#(
  parameter int unsigned TS_DCLKS      = TS_DCLKS_DEF,
  parameter int unsigned READ_DCLKS    = READ_DCLKS_DEF,
  parameter int unsigned SETTLE_FRAMES = 7,
  parameter int unsigned DRDY_WIDTH    = 1
) (
  input  logic                dclk,
  input  logic                rst_dclk,
  input  logic                en,
  input  logic                sync_req,
  input  logic [SAMPLE_W-1:0] sample_data,
  input  logic                sample_valid,
  output logic                sample_ready,
  input  logic                skip_next,
  output logic                drdy,
  output logic                dout,
  output logic                frame_active,
  output logic [2:0]          frame_cnt,
  output logic                underrun,
  output logic [1:0]          state
);

  localparam int unsigned PER_W = $clog2(TS_DCLKS);
  localparam int unsigned SET_W = $clog2(SETTLE_FRAMES + 1);

  adc_state_t          st;
  logic [PER_W-1:0]    per_ctr;
  logic [SET_W-1:0]    settle_ctr;
  logic                skip_q;
  logic                frame_live;
  logic [SAMPLE_W-1:0] last_word;

  logic                per_wrap;
  logic                sync_hit;
  logic                tx_clear;
  logic                tx_load;
  logic [SAMPLE_W-1:0] tx_word;

  always_comb begin
    per_wrap = (per_ctr == PER_W'(TS_DCLKS - 1));
    sync_hit = sync_req && (st != ST_IDLE);
    tx_clear = !en || sync_hit;
    tx_load  = (st == ST_RUN) && (per_ctr == '0) && !skip_q;
    tx_word  = sample_valid ? sample_data : last_word;
  end

  assign state = st;

  always_ff @(posedge dclk or posedge rst_dclk) begin
    if (rst_dclk) begin
      st           <= ST_IDLE;
      per_ctr      <= '0;
      settle_ctr   <= '0;
      skip_q       <= 1'b0;
      frame_live   <= 1'b0;
      last_word    <= '0;
      drdy         <= 1'b0;
      sample_ready <= 1'b0;
      frame_cnt    <= '0;
      underrun     <= 1'b0;
    end else if (!en) begin
      st           <= ST_IDLE;
      per_ctr      <= '0;
      settle_ctr   <= '0;
      skip_q       <= 1'b0;
      frame_live   <= 1'b0;
      last_word    <= '0;
      drdy         <= 1'b0;
      sample_ready <= 1'b0;
      frame_cnt    <= '0;
    end else if (sync_hit) begin
      st           <= ST_SETTLE;
      per_ctr      <= '0;
      settle_ctr   <= '0;
      skip_q       <= 1'b0;
      frame_live   <= 1'b0;
      drdy         <= 1'b0;
      sample_ready <= 1'b0;
    end else begin
      drdy         <= 1'b0;
      sample_ready <= 1'b0;
      unique case (st)
        ST_IDLE: begin
          st         <= ST_SETTLE;
          per_ctr    <= '0;
          settle_ctr <= '0;
        end
        ST_SETTLE: begin
          per_ctr <= per_wrap ? '0 : per_ctr + PER_W'(1);
          if (skip_next) skip_q <= 1'b1;
          if (per_wrap) begin
            settle_ctr <= settle_ctr + SET_W'(1);
            if (32'(settle_ctr) + 32'd1 >= SETTLE_FRAMES) st <= ST_RUN;
          end
        end
        ST_RUN: begin
          per_ctr <= per_wrap ? '0 : per_ctr + PER_W'(1);
          if (per_ctr == '0) begin
            // A skip pulse coinciding with frame start re-arms the latch for the next period.
            skip_q     <= skip_next;
            frame_live <= !skip_q;
            if (!skip_q) begin
              drdy <= 1'b1;
              if (sample_valid) begin
                sample_ready <= 1'b1;
                last_word    <= sample_data;
              end else begin
                underrun <= 1'b1;
              end
            end
          end else begin
            if (skip_next) skip_q <= 1'b1;
            if (frame_live && (32'(per_ctr) < DRDY_WIDTH)) drdy <= 1'b1;
            if (frame_live && (per_ctr == PER_W'(READ_DCLKS))) begin
              frame_cnt  <= frame_cnt + 3'd1;
              frame_live <= 1'b0;
            end
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  adc_shift_tx #(
    .NBITS(READ_DCLKS)
  ) u_shift_tx (
    .dclk    (dclk),
    .rst_dclk(rst_dclk),
    .clear   (tx_clear),
    .load    (tx_load),
    .word    (tx_word),
    .dout    (dout),
    .active  (frame_active)
  );

endmodule

// File: tb/tb_adc_frame_emitter.sv
// Self-checking bench for adc_frame_emitter against a time-since-sync reference model.
module tb_adc_frame_emitter;

  localparam int TS  = 128;
  localparam int RD  = 24;
  localparam int SF  = 7;
  localparam int DW  = 1;
  localparam int LAT = 1 + SF * TS;

  logic        dclk = 1'b0;
  logic        rst_dclk = 1'b0;
  logic        en = 1'b0;
  logic        sync_req = 1'b0;
  logic [23:0] sample_data = '0;
  logic        sample_valid = 1'b0;
  logic        skip_next = 1'b0;
  logic        sample_ready, drdy, dout, frame_active, underrun;
  logic [2:0]  frame_cnt;
  logic [1:0]  state;

  int n_chk = 0;
  int n_fail = 0;

  always #5 dclk = ~dclk;

  adc_frame_emitter #(
    .TS_DCLKS(TS),
    .READ_DCLKS(RD),
    .SETTLE_FRAMES(SF),
    .DRDY_WIDTH(DW)
  ) dut (
    .dclk(dclk), .rst_dclk(rst_dclk), .en(en), .sync_req(sync_req),
    .sample_data(sample_data), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .skip_next(skip_next), .drdy(drdy), .dout(dout), .frame_active(frame_active),
    .frame_cnt(frame_cnt), .underrun(underrun), .state(state)
  );

  // Reference model: everything follows from t, the number of edges since the settle period began.
  bit          running;
  int          t;
  bit          skip_pend, cur_emit;
  logic [23:0] cur_word, last_w;
  logic [2:0]  m_fcnt;
  logic        m_under, m_drdy, m_dout, m_act, m_ready;
  logic [1:0]  m_state;

  task automatic model_edge();
    int u, pos;
    if (rst_dclk) begin
      running = 0; t = 0; skip_pend = 0; cur_emit = 0; cur_word = '0; last_w = '0;
      m_fcnt = '0; m_under = 0; m_drdy = 0; m_dout = 0; m_act = 0; m_ready = 0; m_state = 2'd0;
    end else begin
      m_drdy = 0; m_dout = 0; m_act = 0; m_ready = 0;
      if (!en) begin
        running = 0; t = 0; skip_pend = 0; cur_emit = 0; last_w = '0; m_fcnt = '0; m_state = 2'd0;
      end else if (!running || sync_req) begin
        running = 1; t = 0; skip_pend = 0; cur_emit = 0; m_state = 2'd1;
      end else begin
        t++;
        m_state = (t >= SF * TS) ? 2'd2 : 2'd1;
        u = t - 1 - SF * TS;
        if (u < 0) begin
          if (skip_next) skip_pend = 1;
        end else begin
          pos = u % TS;
          if (pos == 0) begin
            cur_emit  = !skip_pend;
            skip_pend = skip_next;
            if (cur_emit) begin
              if (sample_valid) begin
                cur_word = sample_data; last_w = sample_data; m_ready = 1;
              end else begin
                cur_word = last_w; m_under = 1;
              end
            end
          end else if (skip_next) begin
            skip_pend = 1;
          end
          m_drdy = cur_emit && (pos < DW);
          m_act  = cur_emit && (pos >= 1) && (pos <= RD);
          m_dout = m_act ? cur_word[RD - pos] : 1'b0;
          if (cur_emit && pos == RD) m_fcnt = m_fcnt + 3'd1;
        end
      end
    end
  endtask

  always @(posedge dclk or posedge rst_dclk) model_edge();

  wire [9:0] obs  = {drdy, dout, frame_active, sample_ready, frame_cnt, underrun, state};
  wire [9:0] expv = {m_drdy, m_dout, m_act, m_ready, m_fcnt, m_under, m_state};

  task automatic test_reset();
    #1 rst_dclk = 1'b1;
    #12;
    n_chk++;
    if (obs !== 10'b0) begin n_fail++; $display("FAIL reset_outputs: got %b want %b", obs, 10'b0); end
    @(negedge dclk);
    rst_dclk = 1'b0;
  endtask

  task automatic test_first_frame();
    int lat;
    logic [23:0] word;
    sample_data = 24'hA5C3F0; sample_valid = 1'b1; en = 1'b1;
    lat = -1;
    for (int i = 0; i < LAT + 50; i++) begin
      @(negedge dclk);
      n_chk++;
      if (obs !== expv) begin n_fail++; $display("FAIL first_frame cyc %0d: got %b want %b", i, obs, expv); end
      if (drdy) begin lat = i; break; end
    end
    n_chk++;
    if (lat != LAT) begin n_fail++; $display("FAIL en_to_drdy_latency: got %0d want %0d", lat, LAT); end
    word = '0;
    for (int b = 0; b < RD; b++) begin
      @(negedge dclk);
      n_chk++;
      if (obs !== expv) begin n_fail++; $display("FAIL first_bits bit %0d: got %b want %b", b, obs, expv); end
      word = {word[22:0], dout};
    end
    n_chk++;
    if (word !== 24'hA5C3F0) begin n_fail++; $display("FAIL first_word: got %h want %h", word, 24'hA5C3F0); end
    n_chk++;
    if (frame_cnt !== 3'd1) begin n_fail++; $display("FAIL first_frame_cnt: got %0d want 1", frame_cnt); end
  endtask

  task automatic test_continuous();
    int last_rise, rises, readies;
    bit wrapped;
    logic prev_d;
    logic [2:0] prevf;
    last_rise = -1; rises = 0; readies = 0; wrapped = 0; prev_d = drdy; prevf = frame_cnt;
    for (int i = 0; i < 8 * TS; i++) begin
      sample_data = 24'($urandom);
      @(negedge dclk);
      n_chk++;
      if (obs !== expv) begin n_fail++; $display("FAIL continuous cyc %0d: got %b want %b", i, obs, expv); end
      if (drdy && !prev_d) begin
        if (last_rise >= 0) begin
          n_chk++;
          if (i - last_rise != TS) begin n_fail++; $display("FAIL drdy_spacing: got %0d want %0d", i - last_rise, TS); end
        end
        last_rise = i; rises++;
      end
      if (sample_ready) readies++;
      if (prevf == 3'd7 && frame_cnt == 3'd0) wrapped = 1;
      prevf = frame_cnt; prev_d = drdy;
    end
    n_chk++;
    if (rises != 8) begin n_fail++; $display("FAIL drdy_count: got %0d want 8", rises); end
    n_chk++;
    if (readies != 8) begin n_fail++; $display("FAIL ready_count: got %0d want 8", readies); end
    n_chk++;
    if (!wrapped) begin n_fail++; $display("FAIL frame_cnt_wrap: got 0 want 1"); end
  endtask

  task automatic test_underrun();
    n_chk++;
    if (underrun !== 1'b0) begin n_fail++; $display("FAIL underrun_initial: got %b want 0", underrun); end
    for (int i = 0; i < 4 * TS; i++) begin
      sample_valid = (i >= 10 && i < 10 + TS) ? 1'b0 : (i >= 3 * TS) ? 1'b1 : ($urandom_range(0, 3) != 0);
      sample_data  = 24'($urandom);
      @(negedge dclk);
      n_chk++;
      if (obs !== expv) begin n_fail++; $display("FAIL underrun cyc %0d: got %b want %b", i, obs, expv); end
    end
    n_chk++;
    if (underrun !== 1'b1) begin n_fail++; $display("FAIL underrun_sticky: got %b want 1", underrun); end
  endtask

  task automatic test_skip();
    int dr[5];
    int dq[5];
    int exp_dr[5];
    logic [2:0] f_before;
    exp_dr = '{0, 0, 1, 1, 0};
    dr = '{0, 0, 0, 0, 0};
    dq = '{0, 0, 0, 0, 0};
    sample_valid = 1'b1;
    for (int i = 0; i < TS + 2; i++) begin
      @(negedge dclk);
      n_chk++;
      if (obs !== expv) begin n_fail++; $display("FAIL skip_sync cyc %0d: got %b want %b", i, obs, expv); end
      if (drdy) break;
    end
    f_before = frame_cnt;
    for (int c = 1; c < 5 * TS; c++) begin
      skip_next   = (c == 60) || (c == 3 * TS);
      sample_data = 24'($urandom);
      @(negedge dclk);
      n_chk++;
      if (obs !== expv) begin n_fail++; $display("FAIL skip cyc %0d: got %b want %b", c, obs, expv); end
      dr[c / TS] += int'(drdy);
      dq[c / TS] += int'(dout);
      if (c == TS - 1) f_before = frame_cnt;
      if (c == 2 * TS - 1) begin
        n_chk++;
        if (frame_cnt !== f_before) begin n_fail++; $display("FAIL skip_frame_cnt: got %0d want %0d", frame_cnt, f_before); end
      end
    end
    skip_next = 1'b0;
    for (int p = 0; p < 5; p++) begin
      n_chk++;
      if (dr[p] != exp_dr[p]) begin n_fail++; $display("FAIL skip_drdy period %0d: got %0d want %0d", p, dr[p], exp_dr[p]); end
    end
    n_chk++;
    if (dq[1] + dq[4] != 0) begin n_fail++; $display("FAIL skip_dout: got %0d want 0", dq[1] + dq[4]); end
  endtask

  task automatic test_sync();
    int lat;
    logic [2:0] saved;
    for (int i = 0; i < TS + 2; i++) begin
      @(negedge dclk);
      n_chk++;
      if (obs !== expv) begin n_fail++; $display("FAIL sync_align cyc %0d: got %b want %b", i, obs, expv); end
      if (drdy) break;
    end
    repeat (9) @(negedge dclk);
    saved = frame_cnt;
    sync_req = 1'b1;
    @(negedge dclk);
    sync_req = 1'b0;
    n_chk++;
    if ({drdy, dout, state} !== {1'b0, 1'b0, 2'd1}) begin
      n_fail++; $display("FAIL sync_abort: got %b want %b", {drdy, dout, state}, 4'b0001);
    end
    n_chk++;
    if (frame_cnt !== saved) begin n_fail++; $display("FAIL sync_frame_cnt: got %0d want %0d", frame_cnt, saved); end
    lat = -1;
    for (int i = 1; i < LAT + 50; i++) begin
      @(negedge dclk);
      n_chk++;
      if (obs !== expv) begin n_fail++; $display("FAIL sync_settle cyc %0d: got %b want %b", i, obs, expv); end
      if (drdy) begin lat = i; break; end
    end
    n_chk++;
    if (lat != LAT) begin n_fail++; $display("FAIL sync_to_drdy_latency: got %0d want %0d", lat, LAT); end
  endtask

  task automatic test_en_priority();
    repeat (20) @(negedge dclk);
    en = 1'b0; sync_req = 1'b1;
    @(negedge dclk);
    sync_req = 1'b0;
    n_chk++;
    if (obs !== 10'b0000_000_1_00) begin n_fail++; $display("FAIL en_over_sync: got %b want %b", obs, 10'b0000000100); end
    en = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(negedge dclk);
      n_chk++;
      if (obs !== expv) begin n_fail++; $display("FAIL restart cyc %0d: got %b want %b", j, obs, expv); end
    end
    #2 rst_dclk = 1'b1;
    #1;
    n_chk++;
    if (obs !== 10'b0) begin n_fail++; $display("FAIL async_reset: got %b want %b", obs, 10'b0); end
    @(negedge dclk);
    rst_dclk = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge dclk);
      n_chk++;
      if (obs !== expv) begin n_fail++; $display("FAIL post_reset cyc %0d: got %b want %b", j, obs, expv); end
    end
    n_chk++;
    if (state !== 2'd1) begin n_fail++; $display("FAIL post_reset_state: got %0d want 1", state); end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_continuous();
    test_underrun();
    test_skip();
    test_sync();
    test_en_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
